// File: rtl/tt_um_carlosgs99_div_8by4.sv
// Sequential restoring divider: 8-bit dividend by 4-bit divisor, one quotient bit per clock,
// with a start/busy/done handshake. A zero divisor completes in one cycle with a flag.
//
// state  | meaning
// IDLE   | waiting for start; results from the last operation held
// RUN    | one restoring iteration per clock (or the single divide-by-zero cycle)
// DONE   | results just registered; done high for this one cycle
module tt_um_carlosgs99_div_8by4 #(
    parameter int N_W = 8,
    parameter int D_W = 4
) (
    input  logic           io_clk,
    input  logic           io_rst,
    input  logic           io_start,
    input  logic [N_W-1:0] io_N,
    input  logic [D_W-1:0] io_D,
    output logic           io_busy,
    output logic           io_done,
    output logic           io_div_zero,
    output logic [N_W-1:0] io_Q,
    output logic [D_W-1:0] io_R
);

    localparam int CNT_W = $clog2(N_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state;
    logic [D_W:0]     rem;
    logic [N_W-1:0]   dvd;
    logic [D_W-1:0]   dsr;
    logic [CNT_W-1:0] count;
    logic             dz;

    logic [D_W+1:0]   rem_sh;
    logic [D_W:0]     diff;
    logic             q_bit;
    logic [D_W:0]     rem_nxt;
    logic [N_W-1:0]   dvd_nxt;

    // The dividend register fills with quotient bits from the bottom as it shifts out the top.
    always_comb begin
        rem_sh  = {rem, dvd[N_W-1]};
        diff    = rem_sh[D_W:0] - {1'b0, dsr};
        q_bit   = (rem_sh >= {2'b00, dsr});
        rem_nxt = q_bit ? diff : rem_sh[D_W:0];
        dvd_nxt = {dvd[N_W-2:0], q_bit};
    end

    always_ff @(posedge io_clk) begin
        if (io_rst) begin
            state       <= S_IDLE;
            rem         <= '0;
            dvd         <= '0;
            dsr         <= '0;
            count       <= '0;
            dz          <= 1'b0;
            io_busy     <= 1'b0;
            io_done     <= 1'b0;
            io_div_zero <= 1'b0;
            io_Q        <= '0;
            io_R        <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    io_done <= 1'b0;
                    if (io_start) begin
                        dvd     <= io_N;
                        dsr     <= io_D;
                        rem     <= '0;
                        count   <= '0;
                        dz      <= (io_D == '0);
                        io_busy <= (io_D != '0);
                        state   <= S_RUN;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    if (dz) begin
                        state       <= S_DONE;
                        io_busy     <= 1'b0;
                        io_done     <= 1'b1;
                        io_div_zero <= 1'b1;
                        io_Q        <= '1;
                        io_R        <= '0;
                    end else begin
                        rem   <= rem_nxt;
                        dvd   <= dvd_nxt;
                        count <= count + CNT_W'(1);
                        if (count == LAST) begin
                            state       <= S_DONE;
                            io_busy     <= 1'b0;
                            io_done     <= 1'b1;
                            io_div_zero <= 1'b0;
                            io_Q        <= dvd_nxt;
                            io_R        <= rem_nxt[D_W-1:0];
                        end
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    io_busy <= 1'b0;
                    io_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tt_um_carlosgs99_div_8by4.sv
// Scoreboard bench for the 8-by-4 divider: stimulus pushes expected results computed with
// plain / and %, a negedge monitor pops and compares whenever done is seen.
module tb_tt_um_carlosgs99_div_8by4;

    logic       io_clk = 1'b0;
    logic       io_rst;
    logic       io_start;
    logic [7:0] io_N;
    logic [3:0] io_D;
    logic       io_busy;
    logic       io_done;
    logic       io_div_zero;
    logic [7:0] io_Q;
    logic [3:0] io_R;

    tt_um_carlosgs99_div_8by4 dut (
        .io_clk     (io_clk),
        .io_rst     (io_rst),
        .io_start   (io_start),
        .io_N       (io_N),
        .io_D       (io_D),
        .io_busy    (io_busy),
        .io_done    (io_done),
        .io_div_zero(io_div_zero),
        .io_Q       (io_Q),
        .io_R       (io_R)
    );

    always #5 io_clk = ~io_clk;

    int cyc = 0;
    always @(posedge io_clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] n;
        logic [3:0] d;
        logic [7:0] q;
        logic [3:0] r;
        logic       dz;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model; lat is the number of edges from acceptance to visible done.
    function automatic exp_t model(input logic [7:0] n, input logic [3:0] d, input int accept_cyc);
        exp_t e;
        e.n = n;
        e.d = d;
        if (d == 0) begin
            e.q   = 8'hFF;
            e.r   = 4'd0;
            e.dz  = 1'b1;
            e.cyc = accept_cyc + 1;
        end else begin
            e.q   = 8'(int'(n) / int'(d));
            e.r   = 4'(int'(n) % int'(d));
            e.dz  = 1'b0;
            e.cyc = accept_cyc + 8;
        end
        return e;
    endfunction

    always @(negedge io_clk) begin : monitor
        exp_t e;
        if (!io_rst && io_done) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 expected no pending op (t=%0t)", $time);
            end else begin
                e = sb.pop_front();
                chk("quotient", 32'(io_Q), 32'(e.q));
                chk("remainder", 32'(io_R), 32'(e.r));
                chk("div_zero", 32'(io_div_zero), 32'(e.dz));
                chk("latency", 32'(cyc), 32'(e.cyc));
                if (e.d != 0) begin
                    chk("busy_at_done", 32'(io_busy), 32'd0);
                    chk("invariant", 32'(int'(io_Q) * int'(e.d) + int'(io_R)), 32'(e.n));
                end
            end
        end
    end

    // Called at a negedge while the DUT is in IDLE or DONE; acceptance is the next posedge.
    task automatic issue(input logic [7:0] n, input logic [3:0] d);
        io_start = 1'b1;
        io_N     = n;
        io_D     = d;
        sb.push_back(model(n, d, cyc + 1));
        @(negedge io_clk);
        io_start = 1'b0;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge io_clk);
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending ops expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        io_rst   = 1'b1;
        io_start = 1'b1;
        io_N     = 8'($urandom);
        io_D     = 4'($urandom);
        repeat (2) @(negedge io_clk);
        chk("rst_busy", 32'(io_busy), 32'd0);
        chk("rst_done", 32'(io_done), 32'd0);
        chk("rst_q", 32'(io_Q), 32'd0);
        chk("rst_r", 32'(io_R), 32'd0);
        chk("rst_dz", 32'(io_div_zero), 32'd0);
        io_rst   = 1'b0;
        io_start = 1'b0;
        @(negedge io_clk);
        chk("idle_no_busy", 32'(io_busy), 32'd0);

        issue(8'd200, 4'd13);
        chk("busy_running", 32'(io_busy), 32'd1);
        drain(30);
        issue(8'd225, 4'd15); drain(30);
        issue(8'd7,   4'd9);  drain(30);
        issue(8'd255, 4'd1);  drain(30);

        issue(8'd42, 4'd0);   drain(30);
        repeat (2) @(negedge io_clk);
        chk("hold_dz", 32'(io_div_zero), 32'd1);
        chk("hold_q", 32'(io_Q), 32'hFF);
        issue(8'd42, 4'd6);   drain(30);
        repeat (2) @(negedge io_clk);
        chk("hold_q_idle", 32'(io_Q), 32'd7);

        // Start during RUN is ignored; start held through DONE restarts with no idle cycle.
        io_start = 1'b1; io_N = 8'd100; io_D = 4'd7;
        sb.push_back(model(8'd100, 4'd7, cyc + 1));
        @(negedge io_clk);
        io_start = 1'b0;
        repeat (2) @(negedge io_clk);
        io_start = 1'b1; io_N = 8'd9; io_D = 4'd3;
        @(negedge io_clk);
        io_start = 1'b0; io_N = 8'd100; io_D = 4'd7;
        repeat (4) @(negedge io_clk);
        io_start = 1'b1;
        @(negedge io_clk);
        sb.push_back(model(8'd100, 4'd7, cyc + 1));
        @(negedge io_clk);
        chk("b2b_busy", 32'(io_busy), 32'd1);
        chk("b2b_done_drop", 32'(io_done), 32'd0);
        io_start = 1'b0;
        drain(30);

        // Reset mid-operation: no done may follow (monitor flags any).
        @(negedge io_clk);
        io_start = 1'b1; io_N = 8'd200; io_D = 4'd13;
        @(negedge io_clk);
        io_start = 1'b0;
        repeat (3) @(negedge io_clk);
        io_rst = 1'b1;
        @(negedge io_clk);
        io_rst = 1'b0;
        chk("midrst_busy", 32'(io_busy), 32'd0);
        chk("midrst_q", 32'(io_Q), 32'd0);
        chk("midrst_r", 32'(io_R), 32'd0);
        chk("midrst_dz", 32'(io_div_zero), 32'd0);
        repeat (12) @(negedge io_clk);
        issue(8'd50, 4'd5); drain(30);

        for (int n = 0; n < 256; n++) begin
            for (int d = 0; d < 16; d++) begin
                issue(8'(n), 4'(d));
                drain(30);
            end
        end

        for (int i = 0; i < 300; i++) begin
            issue(8'($urandom), 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0) io_N = 8'($urandom);
            drain(30);
            repeat ($urandom_range(0, 2)) @(negedge io_clk);
        end

        repeat (3) @(negedge io_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
